// File: rtl/fp32_pkg.sv
// Shared fp32 field constants and input classification, used by both the
// quantize (fp32 -> fixed) and dequantize (fixed -> fp32) paths.
package fp32_pkg;

    localparam int FP32_EXP_BIAS  = 127;
    localparam int FP32_MANT_BITS = 23;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational fp32 field splitter: sign, class, biased exponent and the
// 24-bit significand with the hidden bit restored.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]               i_data,
    output logic                      o_sign,
    output fp_class_t                 o_cls,
    output logic [7:0]                o_exp,
    output logic [FP32_MANT_BITS:0]   o_sig
);

    logic [7:0]                w_exp;
    logic [FP32_MANT_BITS-1:0] w_mant;

    assign w_exp  = i_data[30:23];
    assign w_mant = i_data[FP32_MANT_BITS-1:0];
    assign o_sign = i_data[31];
    assign o_exp  = w_exp;
    assign o_sig  = {|w_exp, w_mant};

    // Denormals fold into ZERO: they are far below any fixed-point LSB we support.
    always_comb begin
        o_cls = NORM;
        if (w_exp == 8'h00) begin
            o_cls = ZERO;
        end else if (w_exp == 8'hFF) begin
            o_cls = (w_mant == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp32_to_fxp_quant.sv
// fp32 -> signed fixed-point quantizer: unpack, align+round (RNE on magnitude),
// then sign+clamp, as a 3-stage pipeline sharing one stall enable.
module fp32_to_fxp_quant
    import fp32_pkg::*;
#(
    parameter int FXP_WIDTH = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [FXP_WIDTH-1:0] m_data,
    output logic                 m_sat,
    input  logic                 sat_clear,
    output logic [15:0]          sat_count
);

    localparam int SIG_W = FP32_MANT_BITS + 1;
    localparam logic signed [9:0] K_OFFSET   = 10'(FRAC_BITS - FP32_EXP_BIAS - FP32_MANT_BITS);
    localparam logic signed [9:0] K_LEFT_MAX = 10'(FXP_WIDTH - SIG_W);
    localparam logic [FXP_WIDTH:0]   MAG_POS_LIM = {2'b00, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH:0]   MAG_NEG_LIM = {2'b01, {(FXP_WIDTH-1){1'b0}}};
    localparam logic [FXP_WIDTH-1:0] FXP_MAX     = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH-1:0] FXP_MIN     = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    logic                    w_en;
    logic                    w_sign;
    fp_class_t               w_cls;
    logic [7:0]              w_exp;
    logic [SIG_W-1:0]        w_sig;
    logic signed [9:0]       w_k;

    logic                    r_s1_valid, r_s1_sign;
    fp_class_t               r_s1_cls;
    logic [SIG_W-1:0]        r_s1_sig;
    logic signed [9:0]       r_s1_k;

    logic                    r_s2_valid, r_s2_sign, r_s2_ovf;
    fp_class_t               r_s2_cls;
    logic [FXP_WIDTH:0]      r_s2_mag;

    logic                    r_s3_valid, r_s3_sat;
    logic [FXP_WIDTH-1:0]    r_s3_data;
    logic [15:0]             r_sat_count;

    logic [63:0]             w_sig64, w_shr, w_rem, w_round;
    logic [9:0]              w_rsh;
    logic                    w_guard, w_sticky, w_up, w_big;
    logic [FXP_WIDTH-1:0]    w_mag_neg, w_data;
    logic                    w_sat, w_sat_xfer;
    logic [15:0]             w_cnt_next;

    fp32_unpack u_unpack (
        .i_data (s_data),
        .o_sign (w_sign),
        .o_cls  (w_cls),
        .o_exp  (w_exp),
        .o_sig  (w_sig)
    );

    assign w_k     = $signed({2'b00, w_exp}) + K_OFFSET;
    assign w_en    = !r_s3_valid || m_ready;
    assign s_ready = w_en;

    // Align: left shifts that would push the hidden bit past the output are overflow outright.
    always_comb begin
        w_sig64  = {{(64-SIG_W){1'b0}}, r_s1_sig};
        w_rsh    = 10'(-r_s1_k);
        w_shr    = '0;
        w_rem    = '0;
        w_round  = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_up     = 1'b0;
        w_big    = 1'b0;
        if (!r_s1_k[9]) begin
            if (r_s1_k > K_LEFT_MAX) begin
                w_big = 1'b1;
            end else begin
                w_round = w_sig64 << r_s1_k[3:0];
            end
        end else if (w_rsh <= 10'd25) begin
            w_shr    = w_sig64 >> w_rsh;
            w_guard  = w_sig64[w_rsh[5:0] - 6'd1];
            w_rem    = w_sig64 & ((64'd1 << (w_rsh - 10'd1)) - 64'd1);
            w_sticky = |w_rem;
            w_up     = w_guard & (w_sticky | w_shr[0]);
            w_round  = w_shr + {63'd0, w_up};
        end
        if ((w_round >> (FXP_WIDTH + 1)) != 64'd0) begin
            w_big = 1'b1;
        end
    end

    always_comb begin
        w_mag_neg = ~r_s2_mag[FXP_WIDTH-1:0] + 1'b1;
        w_data    = '0;
        w_sat     = 1'b0;
        case (r_s2_cls)
            ZERO: w_sat = 1'b0;
            INF: begin
                w_sat  = 1'b1;
                w_data = r_s2_sign ? FXP_MIN : FXP_MAX;
            end
            NAN: w_sat = 1'b1;
            default: begin
                if (!r_s2_sign) begin
                    if (r_s2_ovf || r_s2_mag > MAG_POS_LIM) begin
                        w_sat  = 1'b1;
                        w_data = FXP_MAX;
                    end else begin
                        w_data = r_s2_mag[FXP_WIDTH-1:0];
                    end
                end else if (r_s2_ovf || r_s2_mag > MAG_NEG_LIM) begin
                    w_sat  = 1'b1;
                    w_data = FXP_MIN;
                end else begin
                    w_data = w_mag_neg;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= ZERO;
            r_s1_sig   <= '0;
            r_s1_k     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_cls   <= ZERO;
            r_s2_mag   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_sat   <= 1'b0;
            r_s3_data  <= '0;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (s_valid) begin
                r_s1_sign <= w_sign;
                r_s1_cls  <= w_cls;
                r_s1_sig  <= w_sig;
                r_s1_k    <= w_k;
            end
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_cls  <= r_s1_cls;
                r_s2_ovf  <= w_big;
                r_s2_mag  <= w_round[FXP_WIDTH:0];
            end
            if (r_s2_valid) begin
                r_s3_data <= w_data;
                r_s3_sat  <= w_sat;
            end
        end
    end

    assign w_sat_xfer = r_s3_valid && m_ready && r_s3_sat;

    // A clear coinciding with a saturated transfer still counts that transfer.
    always_comb begin
        w_cnt_next = r_sat_count;
        if (sat_clear) begin
            w_cnt_next = w_sat_xfer ? 16'd1 : 16'd0;
        end else if (w_sat_xfer && r_sat_count != 16'hFFFF) begin
            w_cnt_next = r_sat_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_count <= '0;
        end else begin
            r_sat_count <= w_cnt_next;
        end
    end

    assign m_valid   = r_s3_valid;
    assign m_data    = r_s3_data;
    assign m_sat     = r_s3_sat;
    assign sat_count = r_sat_count;

endmodule

// File: tb/tb_fp32_to_fxp_quant.sv
// Bench for fp32_to_fxp_quant (W=32, F=16): real-arithmetic reference model,
// scoreboard monitor on the falling edge, and directed vectors.
module tb_fp32_to_fxp_quant;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'h0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_sat;
    logic        sat_clear = 1'b0;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    int full_seen = 0;
    logic [32:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [32:0] hold_val = '0;
    logic [32:0] out_ref [8];
    logic [32:0] out_bp  [8];

    logic [31:0] vin  [14] = '{32'h3F800000, 32'hC0200000, 32'h37000000, 32'h37C00000,
                               32'h38200000, 32'h38300000, 32'h47800000, 32'hC7000000,
                               32'hFF800000, 32'h7FC00000, 32'h00000001, 32'hC7000001,
                               32'h80000000, 32'h7F800000};
    logic [31:0] vout [14] = '{32'h00010000, 32'hFFFD8000, 32'h00000000, 32'h00000002,
                               32'h00000002, 32'h00000003, 32'h7FFFFFFF, 32'h80000000,
                               32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000,
                               32'h00000000, 32'h7FFFFFFF};
    logic        vsat [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] sbeats [8] = '{32'h3F800000, 32'hC0200000, 32'h38200000, 32'h47800000,
                                32'h7FC00000, 32'hC7000000, 32'h38300000, 32'h41200000};

    fp32_to_fxp_quant #(
        .FXP_WIDTH (32),
        .FRAC_BITS (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sat     (m_sat),
        .sat_clear (sat_clear),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Reference: value = 1.m * 2^(e-127) scaled by 2^16, rounded half-to-even on magnitude.
    function automatic logic [32:0] model(input logic [31:0] f);
        logic   s;
        int     e;
        int     p;
        real    x;
        real    fr;
        longint q;
        s = f[31];
        e = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] == 23'd0) return {1'b1, (s ? 32'h80000000 : 32'h7FFFFFFF)};
            return {1'b1, 32'h0};
        end
        if (e == 0) return {1'b0, 32'h0};
        x = 1.0 + real'(f[22:0]) / 8388608.0;
        p = e - 127 + 16;
        while (p > 0) begin x = x * 2.0; p--; end
        while (p < 0) begin x = x / 2.0; p++; end
        if (x >= 4294967296.0) return {1'b1, (s ? 32'h80000000 : 32'h7FFFFFFF)};
        q = longint'(x);
        if (real'(q) > x) q--;
        fr = x - real'(q);
        if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
        if (!s && q > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (s && q > 64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, (s ? 32'(-q) : 32'(q))};
    endfunction

    always @(negedge clk) begin : mon
        logic [32:0] e_v;
        if (reset) begin
            chk("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
            if (hold_pending) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_beat", 64'({m_sat, m_data}), 64'(hold_val));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h required no beat", {m_sat, m_data});
                end else begin
                    e_v = exp_q.pop_front();
                    chk("scoreboard", 64'({m_sat, m_data}), 64'(e_v));
                end
            end
            if (s_valid && s_ready) exp_q.push_back(model(s_data));
            hold_pending = m_valid && !m_ready;
            hold_val     = {m_sat, m_data};
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic send_one(input logic [31:0] d, input logic [31:0] ed, input logic es);
        int lat;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = d;
        m_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (m_valid) break;
        end
        chk($sformatf("latency[%h]", d), 64'(lat), 64'd3);
        chk($sformatf("data[%h]", d), 64'(m_data), 64'(ed));
        chk($sformatf("sat[%h]", d), 64'(m_sat), 64'(es));
    endtask

    task automatic stream(input bit bp);
        int i;
        int o;
        int cyc;
        logic [31:0] pat;
        pat = 32'b1101_1001_0110_1100_0101_1010_0000_1010;
        i = 0; o = 0; cyc = 0;
        while (o < 8 && cyc < 200) begin
            @(posedge clk); #1;
            if (i < 8) begin
                s_valid = 1'b1;
                s_data  = sbeats[i];
            end else begin
                s_valid = 1'b0;
            end
            m_ready = bp ? pat[cyc % 32] : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) i++;
            if (m_valid && m_ready) begin
                if (bp) out_bp[o] = {m_sat, m_data};
                else    out_ref[o] = {m_sat, m_data};
                o++;
            end
            if (bp && !s_ready) full_seen++;
            cyc++;
        end
        chk(bp ? "stream_bp_count" : "stream_ref_count", 64'(o), 64'd8);
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_sat", 64'(m_sat), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("s_ready_after_reset", 64'(s_ready), 64'd1);

        chk("model_1p0", 64'(model(32'h3F800000)), 64'({1'b0, 32'h00010000}));
        chk("model_tie2p5", 64'(model(32'h38200000)), 64'({1'b0, 32'h00000002}));
        chk("model_neg_min", 64'(model(32'hC7000000)), 64'({1'b0, 32'h80000000}));
        chk("model_pos_sat", 64'(model(32'h47800000)), 64'({1'b1, 32'h7FFFFFFF}));

        for (int v = 0; v < 14; v++) send_one(vin[v], vout[v], vsat[v]);

        @(posedge clk); #1; sat_clear = 1'b1;
        @(posedge clk); #1; sat_clear = 1'b0;
        @(negedge clk);
        chk("sat_count_cleared", 64'(sat_count), 64'd0);
        send_one(32'h47800000, 32'h7FFFFFFF, 1'b1);
        send_one(32'hFF800000, 32'h80000000, 1'b1);
        send_one(32'h7FC00000, 32'h00000000, 1'b1);
        @(negedge clk);
        chk("sat_count_3", 64'(sat_count), 64'd3);
        send_one(32'h47800000, 32'h7FFFFFFF, 1'b1);
        sat_clear = 1'b1;
        @(posedge clk); #1; sat_clear = 1'b0;
        @(negedge clk);
        chk("sat_clear_with_inc", 64'(sat_count), 64'd1);
        force dut.r_sat_count = 16'hFFFF;
        #1;
        release dut.r_sat_count;
        send_one(32'hFF800000, 32'h80000000, 1'b1);
        @(negedge clk);
        chk("sat_count_sticky", 64'(sat_count), 64'hFFFF);

        stream(1'b0);
        stream(1'b1);
        for (int k = 0; k < 8; k++) chk($sformatf("bp_vs_ref[%0d]", k), 64'(out_bp[k]), 64'(out_ref[k]));
        chk("s_ready_low_seen", 64'(full_seen > 0), 64'd1);

        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 32'h3F800000; m_ready = 1'b0;
        @(posedge clk); #1;
        s_data = 32'h40400000;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_sat_count", 64'(sat_count), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(m_valid), 64'd0);
        end
        send_one(32'h40000000, 32'h00020000, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
